pll_lock_monitor: RTL and testbench
===================================

Name: pll_lock_monitor

Overview:
- Parametrised, multi-channel successor to the single-PLL lock indicator that drives a HEX digit.
- Monitors NUM_CH asynchronous PLL `locked` signals and synchronises each one to clk.
- Qualifies lock with a stability window, counts lock-loss events and keeps sticky loss flags.
- Emits one 7-segment code per channel; sits beside the PLLs in the top level, with outputs wired to HEX/LEDR.

Parameters:
- NUM_CH, 2, number of monitored lock inputs (1..6).
- STABLE_CYCLES, 50000, consecutive synchronised-high cycles required before a channel is reported locked (>=1; 1 ms at 50 MHz).
- CNT_W, 8, width of each per-channel loss counter (saturating).
- SEG_LOCK, 7'b1000111, active-low 7-seg code for "L".
- SEG_UNLOCK, 7'b1000001, active-low code for "U".
- SEG_FAULT, 7'b0001110, active-low code for "F".

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  synchronous, active-low reset.
- lock_in  in  NUM_CH  raw asynchronous PLL locked signals, bit i = channel i.
- clr_flags  in  1  synchronous pulse/level; clears all lost flags and loss counters.
- locked_out  out  NUM_CH  qualified lock status per channel.
- lost_flag  out  NUM_CH  sticky: channel lost qualified lock since last clear.
- any_lost  out  1  OR of lost_flag.
- loss_count  out  NUM_CH*CNT_W  per-channel loss count, channel i at [i*CNT_W +: CNT_W].
- hex_out  out  NUM_CH*7  per-channel 7-seg code, channel i at [i*7 +: 7].

Behaviour:
- One clock domain; reset is synchronous and active-low (reset_n sampled on rising clk).
- Reset state, applied to all channels:
  - synchroniser flops 0, FSM UNLOCKED, stability counter 0;
  - locked_out=0, lost_flag=0, any_lost=0, loss_count=0;
  - hex_out = SEG_UNLOCK for every channel.
- Synchroniser: per channel, two flops (sync1 <- lock_in, s <- sync1). The FSM acts on s, i.e. lock_in sampled 2 edges earlier.
- Stability counter: width $clog2(STABLE_CYCLES+1).
- Per-channel FSM, registered, transitions on the rising edge:
  - UNLOCKED: s=1 -> ACQUIRING, cnt=1; if STABLE_CYCLES==1, go directly to LOCKED instead. s=0 -> stay, cnt=0.
  - ACQUIRING:
    - s=0 -> UNLOCKED, cnt=0; no loss counted (glitch during acquisition).
    - s=1 and cnt==STABLE_CYCLES-1 -> LOCKED.
    - s=1 otherwise -> cnt+1.
  - LOCKED: s=0 -> UNLOCKED, cnt=0, set lost_flag, loss_count+1 (saturating at all-ones); s=1 -> stay.
- locked_out[i] is 1 exactly when FSM i is in LOCKED (registered state decode).
- Latency:
  - lock_in sampled high at edge e and held -> locked_out rises at edge e+1+STABLE_CYCLES.
  - lock_in sampled low at edge e while LOCKED -> locked_out falls, and flag/count update, at edge e+2.
- clr_flags=1 at an edge clears lost_flag and loss_count of all channels.
  - Simultaneous loss event on channel i: loss wins, so lost_flag[i]=1 and loss_count[i]=1.
  - Channels without an event clear.
- clr_flags does not affect FSM state or locked_out.
- Loss counter saturates: at 2^CNT_W-1 a further loss leaves the value unchanged; lost_flag stays 1.
- hex_out priority per channel: LOCKED -> SEG_LOCK; else lost_flag=1 -> SEG_FAULT; else SEG_UNLOCK. It is registered and updates on the same edge as locked_out/lost_flag.
- any_lost is registered and coincident with lost_flag.
- Reset asserted mid-acquisition or while LOCKED returns to reset state on that edge. After release, the channel re-qualifies from zero and no loss is counted for the reset.
- Channels are fully independent; simultaneous events on several channels are each handled in the same cycle.

Test Plan:
Run with NUM_CH=2, STABLE_CYCLES=4, CNT_W=3.
1. Reset, then lock_in=2'b01 held -> locked_out[0] rises exactly 5 edges after first sampling edge; hex_out[6:0]=1000111; channel 1 stays 1000001.
2. Channel 0 locked, lock_in[0] dropped for 1 cycle -> locked_out[0] falls 2 edges later; lost_flag[0]=1, loss_count[0]=1, any_lost=1; hex shows 0001110 until relock (then 1000111).
3. lock_in[1] high for 3 cycles then low, repeated -> locked_out[1] never asserts, loss_count[1]=0, lost_flag[1]=0.
4. Eight lock/loss cycles on channel 0 -> loss_count[0] saturates at 7; clr_flags pulse -> count 0, flag 0, locked_out unchanged.
5. clr_flags asserted on the same edge as a channel-0 loss -> lost_flag[0]=1, loss_count[0]=1, while channel 1 (count 2) clears to 0.
6. reset_n low for 1 cycle while both channels LOCKED with lost flags set -> all outputs at reset values; re-lock takes full 5 cycles; loss_count remains 0.

Source files
------------

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: synchronises NUM_CH PLL lock inputs, qualifies lock over a stability window,
// tracks sticky loss flags and saturating loss counts, and drives a 7-seg code per channel.
module pll_lock_monitor #(
    parameter int         NUM_CH        = 2,
    parameter int         STABLE_CYCLES = 50000,
    parameter int         CNT_W         = 8,
    parameter logic [6:0] SEG_LOCK      = 7'b1000111,
    parameter logic [6:0] SEG_UNLOCK    = 7'b1000001,
    parameter logic [6:0] SEG_FAULT     = 7'b0001110
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       lock_in,
    input  logic                    clr_flags,
    output logic [NUM_CH-1:0]       locked_out,
    output logic [NUM_CH-1:0]       lost_flag,
    output logic                    any_lost,
    output logic [NUM_CH*CNT_W-1:0] loss_count,
    output logic [NUM_CH*7-1:0]     hex_out
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRING, LOCKED} state_t;
    logic [NUM_CH-1:0] lost_d;
    logic              any_q;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic [CNT_W-1:0] lcnt_q, lcnt_d;
        logic [6:0]       hex_q;
        logic             sync1_q, sync2_q, lost_q, loss;
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            if (state_q == UNLOCKED) begin
                state_d = sync2_q ? (STABLE_CYCLES == 1 ? LOCKED : ACQUIRING) : UNLOCKED;
                cnt_d   = sync2_q ? CW'(1) : '0;
            end else if (state_q == ACQUIRING) begin
                state_d = !sync2_q ? UNLOCKED : (cnt_q == CW'(STABLE_CYCLES - 1)) ? LOCKED : ACQUIRING;
                cnt_d   = sync2_q ? cnt_q + CW'(1) : '0;
            end else begin
                state_d = sync2_q ? LOCKED : UNLOCKED;
            end
        end
        // A loss on the same edge as a clear wins: flag set, count restarts at 1.
        assign loss      = (state_q == LOCKED) && !sync2_q;
        assign lost_d[c] = loss || (lost_q && !clr_flags);
        assign lcnt_d    = loss ? (clr_flags ? CNT_W'(1) : (&lcnt_q ? lcnt_q : lcnt_q + CNT_W'(1)))
                                : (clr_flags ? '0 : lcnt_q);
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= UNLOCKED;
                cnt_q   <= '0;
                lost_q  <= 1'b0;
                lcnt_q  <= '0;
                hex_q   <= SEG_UNLOCK;
            end else begin
                sync1_q <= lock_in[c];
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lost_q  <= lost_d[c];
                lcnt_q  <= lcnt_d;
                hex_q   <= (state_d == LOCKED) ? SEG_LOCK : lost_d[c] ? SEG_FAULT : SEG_UNLOCK;
            end
        end
        assign locked_out[c]                = (state_q == LOCKED);
        assign lost_flag[c]                 = lost_q;
        assign loss_count[c*CNT_W +: CNT_W] = lcnt_q;
        assign hex_out[c*7 +: 7]            = hex_q;
    end
    always_ff @(posedge clk) begin
        any_q <= reset_n ? |lost_d : 1'b0;
    end
    assign any_lost = any_q;
endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: scoreboard-driven checks of lock qualification, loss tracking,
// clear/loss collision, saturation and mid-run reset with NUM_CH=2, STABLE_CYCLES=4, CNT_W=3.
module tb_pll_lock_monitor;
    localparam logic [6:0] L = 7'b1000111;
    localparam logic [6:0] U = 7'b1000001;
    localparam logic [6:0] F = 7'b0001110;

    typedef struct packed {
        logic [1:0]  lk;
        logic [13:0] hex;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr_flags = 1'b0;
    logic [1:0]  lock_in = 2'b00;
    logic [1:0]  locked_out, lost_flag;
    logic        any_lost;
    logic [5:0]  loss_count;
    logic [13:0] hex_out;

    int tests = 0;
    int fails = 0;
    obs_t       exp_q[$];
    logic [2:0] cnt_exp_q[$];

    pll_lock_monitor #(.NUM_CH(2), .STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .lock_in(lock_in), .clr_flags(clr_flags),
        .locked_out(locked_out), .lost_flag(lost_flag), .any_lost(any_lost),
        .loss_count(loss_count), .hex_out(hex_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        reset_n = 1'b0;
        lock_in = 2'b00;
        clr_flags = 1'b0;
        tick();
        tick();
        tests++;
        if (locked_out !== 2'b00 || lost_flag !== 2'b00 || any_lost !== 1'b0 || loss_count !== 6'd0) begin
            fails++;
            $display("FAIL reset_state: got locked=%b lost=%b any=%b count=%o, expected all zero",
                     locked_out, lost_flag, any_lost, loss_count);
        end
        e = '{lk: 2'b00, hex: {U, U}};
        tests++;
        if (hex_out !== e.hex) begin
            fails++;
            $display("FAIL reset_hex: got %b expected %b", hex_out, e.hex);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_acquire();
        obs_t e, o;
        lock_in = 2'b01;
        for (int j = 1; j <= 7; j++) begin
            e.lk  = (j >= 6) ? 2'b01 : 2'b00;
            e.hex = (j >= 6) ? {U, L} : {U, U};
            exp_q.push_back(e);
            tick();
            o = exp_q.pop_front();
            tests++;
            if ({locked_out, hex_out} !== o) begin
                fails++;
                $display("FAIL acquire_edge%0d: got locked=%b hex=%b expected locked=%b hex=%b",
                         j, locked_out, hex_out, o.lk, o.hex);
            end
        end
    endtask

    task automatic test_loss();
        obs_t e, o;
        lock_in = 2'b00;
        for (int j = 1; j <= 7; j++) begin
            e.lk  = (j <= 2 || j == 7) ? 2'b01 : 2'b00;
            e.hex = (j >= 3 && j <= 6) ? {U, F} : {U, L};
            exp_q.push_back(e);
            tick();
            if (j == 1) lock_in = 2'b01;
            o = exp_q.pop_front();
            tests++;
            if ({locked_out, hex_out} !== o) begin
                fails++;
                $display("FAIL loss_edge%0d: got locked=%b hex=%b expected locked=%b hex=%b",
                         j, locked_out, hex_out, o.lk, o.hex);
            end
            if (j == 3) begin
                tests++;
                if (lost_flag !== 2'b01 || loss_count !== {3'd0, 3'd1} || any_lost !== 1'b1) begin
                    fails++;
                    $display("FAIL loss_flags: got lost=%b count=%o any=%b expected lost=01 count=01 any=1",
                             lost_flag, loss_count, any_lost);
                end
            end
        end
    endtask

    task automatic test_glitch();
        obs_t e, o;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                lock_in = {(k < 3), 1'b1};
                e = '{lk: 2'b01, hex: {U, L}};
                exp_q.push_back(e);
                tick();
                o = exp_q.pop_front();
                tests++;
                if ({locked_out, hex_out} !== o) begin
                    fails++;
                    $display("FAIL glitch_r%0d_k%0d: got locked=%b hex=%b expected locked=%b hex=%b",
                             r, k, locked_out, hex_out, o.lk, o.hex);
                end
            end
        end
        lock_in = 2'b01;
        repeat (3) tick();
        tests++;
        if (locked_out[1] !== 1'b0 || lost_flag[1] !== 1'b0 || loss_count[5:3] !== 3'd0) begin
            fails++;
            $display("FAIL glitch_ch1: got locked=%b lost=%b count=%0d expected 0 0 0",
                     locked_out[1], lost_flag[1], loss_count[5:3]);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] c;
        for (int i = 0; i < 8; i++) begin
            cnt_exp_q.push_back((2 + i > 7) ? 3'd7 : 3'(2 + i));
            lock_in = 2'b00;
            tick();
            lock_in = 2'b01;
            repeat (6) tick();
            c = cnt_exp_q.pop_front();
            tests++;
            if (loss_count[2:0] !== c || locked_out[0] !== 1'b1 || lost_flag[0] !== 1'b1) begin
                fails++;
                $display("FAIL saturate_iter%0d: got count=%0d locked=%b lost=%b expected count=%0d locked=1 lost=1",
                         i, loss_count[2:0], locked_out[0], lost_flag[0], c);
            end
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tests++;
        if (loss_count !== 6'd0 || lost_flag !== 2'b00 || any_lost !== 1'b0) begin
            fails++;
            $display("FAIL clear_flags: got count=%o lost=%b any=%b expected 00 00 0",
                     loss_count, lost_flag, any_lost);
        end
        tests++;
        if (locked_out !== 2'b01 || hex_out !== {U, L}) begin
            fails++;
            $display("FAIL clear_keeps_lock: got locked=%b hex=%b expected 01 %b", locked_out, hex_out, {U, L});
        end
    endtask

    task automatic test_clr_collide();
        lock_in = 2'b11;
        repeat (6) tick();
        tests++;
        if (locked_out !== 2'b11) begin
            fails++;
            $display("FAIL collide_prelock: got locked=%b expected 11", locked_out);
        end
        for (int i = 0; i < 2; i++) begin
            lock_in = 2'b01;
            tick();
            lock_in = 2'b11;
            repeat (6) tick();
        end
        tests++;
        if (loss_count[5:3] !== 3'd2 || locked_out !== 2'b11) begin
            fails++;
            $display("FAIL collide_ch1_count: got count=%0d locked=%b expected 2 11", loss_count[5:3], locked_out);
        end
        lock_in = 2'b10;
        tick();
        lock_in = 2'b11;
        tick();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tests++;
        if (lost_flag !== 2'b01 || loss_count !== {3'd0, 3'd1} || any_lost !== 1'b1) begin
            fails++;
            $display("FAIL collide_flags: got lost=%b count=%o any=%b expected lost=01 count=01 any=1",
                     lost_flag, loss_count, any_lost);
        end
        tests++;
        if (locked_out !== 2'b10 || hex_out !== {L, F}) begin
            fails++;
            $display("FAIL collide_state: got locked=%b hex=%b expected 10 %b", locked_out, hex_out, {L, F});
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        repeat (6) tick();
        lock_in = 2'b01;
        tick();
        lock_in = 2'b11;
        repeat (6) tick();
        tests++;
        if (locked_out !== 2'b11 || lost_flag !== 2'b11) begin
            fails++;
            $display("FAIL resetmid_pre: got locked=%b lost=%b expected 11 11", locked_out, lost_flag);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tests++;
        if (locked_out !== 2'b00 || lost_flag !== 2'b00 || any_lost !== 1'b0 || loss_count !== 6'd0
            || hex_out !== {U, U}) begin
            fails++;
            $display("FAIL resetmid_state: got locked=%b lost=%b any=%b count=%o hex=%b expected reset values",
                     locked_out, lost_flag, any_lost, loss_count, hex_out);
        end
        for (int j = 1; j <= 7; j++) begin
            e.lk  = (j >= 6) ? 2'b11 : 2'b00;
            e.hex = (j >= 6) ? {L, L} : {U, U};
            exp_q.push_back(e);
            tick();
            o = exp_q.pop_front();
            tests++;
            if ({locked_out, hex_out} !== o) begin
                fails++;
                $display("FAIL relock_edge%0d: got locked=%b hex=%b expected locked=%b hex=%b",
                         j, locked_out, hex_out, o.lk, o.hex);
            end
        end
        tests++;
        if (loss_count !== 6'd0 || lost_flag !== 2'b00 || any_lost !== 1'b0) begin
            fails++;
            $display("FAIL relock_no_loss: got count=%o lost=%b any=%b expected 00 00 0",
                     loss_count, lost_flag, any_lost);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_loss();
        test_glitch();
        test_saturate();
        test_clr_collide();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
